writeback_stage: RTL and testbench

//   Final pipeline stage; writer side of the regfile write port that the decode stage reads.

---
 rtl/writeback_stage.sv | 139 +++++++++++++
 tb/tb_writeback_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results directly and completes loads once the
// data-memory response arrives, driving a registered single-cycle regfile write.
module writeback_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_rf_wr_en_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [1:0]      mem_addr_lo_i,
    input  logic [XLEN-1:0] mem_alu_res_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_rf_wr_en_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_rd_res_o,
    output logic            stall_o,
    output logic            timeout_err_o
);

    localparam int            CW        = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(LOAD_TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [4:0]      ld_rd_q;
    logic            ld_wr_en_q;
    logic [2:0]      ld_funct3_q;
    logic [1:0]      ld_addr_lo_q;
    logic            wb_rf_wr_en_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_rd_res_q;
    logic            timeout_err_q;
    logic            accept;
    logic [XLEN:0]   load_ext;

    // Returns {legal, value}; illegal funct3 yields {0, 0} so the write is suppressed.
    function automatic logic [XLEN:0] extract_load(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] rdata
    );
        logic [7:0]    byte_v;
        logic [15:0]   half_v;
        logic [XLEN:0] res_v;
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  res_v = {1'b1, {24{byte_v[7]}}, byte_v};
            3'b001:  res_v = {1'b1, {16{half_v[15]}}, half_v};
            3'b010:  res_v = {1'b1, rdata};
            3'b100:  res_v = {1'b1, 24'h000000, byte_v};
            3'b101:  res_v = {1'b1, 16'h0000, half_v};
            default: res_v = {1'b0, {XLEN{1'b0}}};
        endcase
        return res_v;
    endfunction

    assign mem_ready_o   = !rst && (state_q == ST_IDLE);
    assign stall_o       = !rst && (state_q == ST_WAIT_LOAD);
    assign accept        = mem_valid_i && mem_ready_o;
    assign cnt_d         = cnt_q + CW'(1);
    assign load_ext      = extract_load(ld_funct3_q, ld_addr_lo_q, dmem_rdata_i);
    assign wb_rf_wr_en_o = wb_rf_wr_en_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_rd_res_o   = wb_rd_res_q;
    assign timeout_err_o = timeout_err_q;

    // Stage FSM with registered regfile write port and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ld_rd_q       <= 5'd0;
            ld_wr_en_q    <= 1'b0;
            ld_funct3_q   <= 3'd0;
            ld_addr_lo_q  <= 2'd0;
            wb_rf_wr_en_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_rd_res_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && mem_is_load_i) begin
                        ld_rd_q       <= mem_rd_i;
                        ld_wr_en_q    <= mem_rf_wr_en_i;
                        ld_funct3_q   <= mem_funct3_i;
                        ld_addr_lo_q  <= mem_addr_lo_i;
                        cnt_q         <= '0;
                        wb_rf_wr_en_q <= 1'b0;
                        state_q       <= ST_WAIT_LOAD;
                    end else if (accept) begin
                        wb_rf_wr_en_q <= mem_rf_wr_en_i && (mem_rd_i != 5'd0);
                        wb_rd_q       <= mem_rd_i;
                        wb_rd_res_q   <= mem_alu_res_i;
                    end else begin
                        wb_rf_wr_en_q <= 1'b0;
                    end
                end
                ST_WAIT_LOAD: begin
                    // A response arriving on the final allowed cycle still completes the load.
                    if (dmem_rvalid_i) begin
                        wb_rf_wr_en_q <= load_ext[XLEN] && ld_wr_en_q && (ld_rd_q != 5'd0);
                        wb_rd_q       <= ld_rd_q;
                        wb_rd_res_q   <= load_ext[XLEN-1:0];
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else if (cnt_d == CNT_LIMIT) begin
                        wb_rf_wr_en_q <= 1'b0;
                        timeout_err_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else begin
                        wb_rf_wr_en_q <= 1'b0;
                        cnt_q         <= cnt_d;
                    end
                end
                default: begin
                    wb_rf_wr_en_q <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and random checks of writeback_stage against a transaction-level model
// of ALU retirement, load extraction, timeout and reset behaviour.
module tb_writeback_stage;

    localparam int LOAD_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic        mem_rf_wr_en_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic [31:0] mem_alu_res_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_rf_wr_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_rd_res_o;
    logic        stall_o;
    logic        timeout_err_o;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic        exp_err;

    writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_rd_i       (mem_rd_i),
        .mem_rf_wr_en_i (mem_rf_wr_en_i),
        .mem_is_load_i  (mem_is_load_i),
        .mem_funct3_i   (mem_funct3_i),
        .mem_addr_lo_i  (mem_addr_lo_i),
        .mem_alu_res_i  (mem_alu_res_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .wb_rf_wr_en_o  (wb_rf_wr_en_o),
        .wb_rd_o        (wb_rd_o),
        .wb_rd_res_o    (wb_rd_res_o),
        .stall_o        (stall_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Load result from the architectural rules, using plain integer arithmetic: {legal, value}.
    function automatic logic [32:0] ref_load(input int f3, input int a, input logic [31:0] w);
        longint wl;
        longint b;
        longint h;
        longint v;
        wl = longint'(w);
        b  = (wl >> (8 * a)) % 256;
        h  = (wl >> (16 * (a / 2))) % 65536;
        case (f3)
            0:       v = (b >= 128) ? b + 64'd4294967040 : b;
            1:       v = (h >= 32768) ? h + 64'd4294901760 : h;
            2:       v = wl;
            4:       v = b;
            5:       v = h;
            default: return {1'b0, 32'h00000000};
        endcase
        return {1'b1, v[31:0]};
    endfunction

    task automatic check_hold(input string tag);
        check({tag, "_wen"}, {31'd0, wb_rf_wr_en_o}, 32'd0);
        check({tag, "_rd"},  {27'd0, wb_rd_o}, {27'd0, exp_rd});
        check({tag, "_res"}, wb_rd_res_o, exp_res);
    endtask

    task automatic idle_cycle();
        mem_valid_i   = 1'b0;
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i  = $urandom;
        tick();
        dmem_rvalid_i = 1'b0;
        check_hold("idle");
        check("idle_ready", {31'd0, mem_ready_o}, 32'd1);
    endtask

    // Presents one ALU op; leaves mem_valid_i high so calls chain back-to-back.
    task automatic alu_op(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        check("alu_ready", {31'd0, mem_ready_o}, 32'd1);
        mem_valid_i    = 1'b1;
        mem_is_load_i  = 1'b0;
        mem_rd_i       = rd;
        mem_rf_wr_en_i = wen;
        mem_alu_res_i  = res;
        mem_funct3_i   = 3'($urandom);
        mem_addr_lo_i  = 2'($urandom);
        dmem_rvalid_i  = 1'($urandom);
        dmem_rdata_i   = $urandom;
        tick();
        dmem_rvalid_i  = 1'b0;
        exp_rd  = rd;
        exp_res = res;
        check("alu_wen", {31'd0, wb_rf_wr_en_o}, {31'd0, (wen && rd != 5'd0)});
        check("alu_rd",  {27'd0, wb_rd_o}, {27'd0, exp_rd});
        check("alu_res", wb_rd_res_o, exp_res);
        check("alu_stall", {31'd0, stall_o}, 32'd0);
    endtask

    // Accepts a load, waits 'delay' response-free cycles, then returns rdata.
    task automatic load_op(input logic [4:0] rd, input logic wen, input int f3, input int a,
                           input logic [31:0] w, input int delay);
        logic [32:0] r;
        mem_valid_i    = 1'b1;
        mem_is_load_i  = 1'b1;
        mem_rd_i       = rd;
        mem_rf_wr_en_i = wen;
        mem_funct3_i   = 3'(f3);
        mem_addr_lo_i  = 2'(a);
        mem_alu_res_i  = $urandom;
        dmem_rvalid_i  = 1'b1;
        dmem_rdata_i   = $urandom;
        tick();
        mem_valid_i    = 1'b0;
        mem_is_load_i  = 1'b0;
        dmem_rvalid_i  = 1'b0;
        check_hold("ld_acc");
        check("ld_acc_stall", {31'd0, stall_o}, 32'd1);
        check("ld_acc_ready", {31'd0, mem_ready_o}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("ld_wait_stall", {31'd0, stall_o}, 32'd1);
            check("ld_wait_wen", {31'd0, wb_rf_wr_en_o}, 32'd0);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = w;
        tick();
        dmem_rvalid_i = 1'b0;
        r       = ref_load(f3, a, w);
        exp_rd  = rd;
        exp_res = r[31:0];
        check("ld_wen", {31'd0, wb_rf_wr_en_o}, {31'd0, (r[32] && wen && rd != 5'd0)});
        check("ld_rd",  {27'd0, wb_rd_o}, {27'd0, exp_rd});
        check("ld_res", wb_rd_res_o, exp_res);
        check("ld_stall", {31'd0, stall_o}, 32'd0);
        check("ld_ready", {31'd0, mem_ready_o}, 32'd1);
        check("ld_err", {31'd0, timeout_err_o}, {31'd0, exp_err});
    endtask

    initial begin
        rst            = 1'b1;
        mem_valid_i    = 1'b0;
        mem_rd_i       = 5'd0;
        mem_rf_wr_en_i = 1'b0;
        mem_is_load_i  = 1'b0;
        mem_funct3_i   = 3'd0;
        mem_addr_lo_i  = 2'd0;
        mem_alu_res_i  = 32'd0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = 32'd0;
        exp_rd         = 5'd0;
        exp_res        = 32'd0;
        exp_err        = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_err", {31'd0, timeout_err_o}, 32'd0);
        check_hold("rst");
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, mem_ready_o}, 32'd1);

        // Back-to-back ALU ops
        alu_op(5'd5, 1'b1, 32'h00001234);
        alu_op(5'd6, 1'b1, 32'hFFFF0000);
        check("b2b_ready", {31'd0, mem_ready_o}, 32'd1);
        idle_cycle();

        // LB at byte 3, response two cycles after accept
        load_op(5'd7, 1'b1, 0, 3, 32'h80AABBCC, 1);
        check("lb_const", wb_rd_res_o, 32'hFFFFFF80);
        load_op(5'd8, 1'b1, 5, 2, 32'h80017FFF, 0);
        check("lhu_const", wb_rd_res_o, 32'h00008001);
        load_op(5'd9, 1'b1, 1, 0, 32'h80017FFF, 2);
        check("lh_const", wb_rd_res_o, 32'h00007FFF);

        // Writes to x0 never assert the enable
        alu_op(5'd0, 1'b1, 32'hDEADBEEF);
        mem_valid_i = 1'b0;
        load_op(5'd0, 1'b1, 2, 0, 32'hCAFEF00D, 1);

        // Illegal funct3 and a response on the last allowed wait cycle
        load_op(5'd10, 1'b1, 3, 1, 32'h12345678, 0);
        load_op(5'd11, 1'b1, 2, 0, 32'hA5A5A5A5, LOAD_TIMEOUT - 1);

        // Timeout: no response for LOAD_TIMEOUT cycles
        mem_valid_i    = 1'b1;
        mem_is_load_i  = 1'b1;
        mem_rd_i       = 5'd12;
        mem_rf_wr_en_i = 1'b1;
        mem_funct3_i   = 3'd2;
        tick();
        mem_valid_i    = 1'b0;
        mem_is_load_i  = 1'b0;
        check("to_stall0", {31'd0, stall_o}, 32'd1);
        for (int i = 1; i < LOAD_TIMEOUT; i++) begin
            tick();
            check("to_stall", {31'd0, stall_o}, 32'd1);
            check("to_err_early", {31'd0, timeout_err_o}, 32'd0);
        end
        tick();
        exp_err = 1'b1;
        check("to_err", {31'd0, timeout_err_o}, 32'd1);
        check("to_ready", {31'd0, mem_ready_o}, 32'd1);
        check_hold("to");
        idle_cycle();
        check("to_sticky", {31'd0, timeout_err_o}, 32'd1);
        alu_op(5'd13, 1'b1, 32'h0BADC0DE);
        mem_valid_i = 1'b0;

        // Random mix
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                alu_op(5'($urandom_range(0, 31)), 1'($urandom), $urandom);
                if ($urandom_range(0, 2) == 0) mem_valid_i = 1'b0;
            end else begin
                mem_valid_i = 1'b0;
                load_op(5'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 3)), $urandom,
                        ($urandom_range(0, 7) == 0) ? LOAD_TIMEOUT - 1 : int'($urandom_range(0, 4)));
            end
        end
        mem_valid_i = 1'b0;
        idle_cycle();
        check("rand_err", {31'd0, timeout_err_o}, 32'd1);

        // Reset during WAIT_LOAD, response after reset
        load_op(5'd14, 1'b1, 2, 0, 32'h11112222, 0);
        mem_valid_i    = 1'b1;
        mem_is_load_i  = 1'b1;
        mem_rd_i       = 5'd15;
        mem_rf_wr_en_i = 1'b1;
        mem_funct3_i   = 3'd2;
        tick();
        mem_valid_i    = 1'b0;
        mem_is_load_i  = 1'b0;
        tick();
        check("rl_stall", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rl_ready_in_rst", {31'd0, mem_ready_o}, 32'd0);
        check("rl_stall_in_rst", {31'd0, stall_o}, 32'd0);
        tick();
        rst          = 1'b0;
        exp_rd       = 5'd0;
        exp_res      = 32'd0;
        exp_err      = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h33334444;
        #1;
        check("rl_err", {31'd0, timeout_err_o}, 32'd0);
        check("rl_ready", {31'd0, mem_ready_o}, 32'd1);
        check_hold("rl_rst");
        tick();
        dmem_rvalid_i = 1'b0;
        check_hold("rl_after");
        check("rl_stall_after", {31'd0, stall_o}, 32'd0);
        check("rl_err_after", {31'd0, timeout_err_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
